mystery_prime_detector: RTL and testbench
=========================================

Name: mystery_prime_detector

Overview:
- Six single-bit inputs a..f form a 6-bit unsigned word N = {a,b,c,d,e,f}, with a as MSB and f as LSB.
- Output x asserts when N is a prime number in the range 0..63.
- The block is a small registered decision unit. It sits behind board switches or upstream logic and drives an LED or status flag.
- One clock domain; synchronous active-high reset.

Parameters:
- none

Ports:
- clk    input   1  system clock; all state updates on the rising edge
- reset  input   1  synchronous reset, active-high
- a      input   1  bit 5 of N (MSB)
- b      input   1  bit 4 of N
- c      input   1  bit 3 of N
- d      input   1  bit 2 of N
- e      input   1  bit 1 of N
- f      input   1  bit 0 of N (LSB)
- x      output  1  registered prime flag for N

Behaviour:
- Interface: one clock; reset is synchronous and active-high (ports clk, reset).
- Reset:
  - When reset = 1 at a rising clk edge, x = 0 on the next cycle.
  - The internal input register also clears to 6'd0.
  - Reset takes priority over the sampled inputs.
- Input stage: on each rising edge with reset = 0, {a,b,c,d,e,f} is captured into the 6-bit register n_q.
- Decode: the combinational function is_prime(n_q) = 1 exactly for N in {2,3,5,7,11,13,17,19,23,29,31,37,41,43,47,53,59,61}. It is 0 for every other value, including 0 and 1.
- Output stage: x is registered: x <= is_prime(n_q) on each rising edge with reset = 0.
- Latency:
  - An input held stable across edge k appears in n_q after edge k and in x after edge k+1.
  - Total latency is 2 clock cycles. Throughput is one new input per cycle.
- Reset mid-operation: any in-flight value is discarded. x stays 0 until 2 edges after reset deasserts, then shows the decode of the input captured at the first post-reset edge.
- Inputs are assumed synchronous to clk; no metastability synchronisers are included.
- x is glitch-free because it is driven directly by a flop.
- No X propagation is allowed. All 64 input codes are defined: 18 codes give 1 and 46 codes give 0.

Decomposition:
- Shared package mystery_pkg:
  - localparam N_W = 6
  - a 64-bit localparam PRIME_MASK with bit i = 1 iff i is prime, i.e. 64'h28208A20_A08A28AC.
- One sub-module, mystery_prime_lut:
  - purely combinational; input [5:0] n, output is_prime.
  - Implemented as a full 64-way case decode.
  - A package-mask lookup is an acceptable alternative, provided both agree.
- Top level contains only the input register, the output register and the reset logic.

Test Plan:
- Reset: hold reset = 1 for 3 cycles with N = 6'd2 -> x = 0 throughout. Release reset -> x = 1 exactly 2 edges later.
- Exhaustive sweep: apply N = 0..63, one value per cycle (10 ns period) -> x at cycle k+2 equals PRIME_MASK[k]. Total of 18 ones over the sweep.
- Boundaries:
  - N = 0 -> x = 0; N = 1 -> x = 0; N = 2 -> x = 1.
  - N = 63 -> x = 0; N = 61 -> x = 1.
- Odd composites: N = 9, 15, 25, 49 -> x = 0 for each. N = 4 (even composite) -> x = 0.
- Back-to-back toggling: alternate N = 31 and N = 32 every cycle -> x alternates 1, 0 with 2-cycle latency and no missed sample.
- Mid-stream reset: during the sweep at N = 37, assert reset for 1 cycle -> x = 0 for the following 2 edges. Decoding then resumes correctly from the value presented after reset.

Source files
------------

// File: rtl/mystery_pkg.sv
// Shared constants for the prime detector: operand width and reference prime mask.
package mystery_pkg;

  localparam int unsigned N_W = 6;

  // Bit i is set exactly when i is prime, for i in 0..63.
  localparam logic [63:0] PRIME_MASK = 64'h28208A20_A08A28AC;

  // Mask-based lookup, kept alongside the case decode as a cross-reference.
  function automatic logic mask_is_prime(input logic [N_W-1:0] n);
    return PRIME_MASK[n];
  endfunction

endpackage

// File: rtl/mystery_prime_lut.sv
// Combinational primality decode of a 6-bit value via a full 64-way case table.
module mystery_prime_lut
  import mystery_pkg::*;
(
  input  logic [N_W-1:0] n,
  output logic           is_prime
);

  // Every one of the 64 codes is listed so no value can decode to X.
  always_comb begin
    is_prime = 1'b0;
    case (n)
      6'd0:  is_prime = 1'b0;
      6'd1:  is_prime = 1'b0;
      6'd2:  is_prime = 1'b1;
      6'd3:  is_prime = 1'b1;
      6'd4:  is_prime = 1'b0;
      6'd5:  is_prime = 1'b1;
      6'd6:  is_prime = 1'b0;
      6'd7:  is_prime = 1'b1;
      6'd8:  is_prime = 1'b0;
      6'd9:  is_prime = 1'b0;
      6'd10: is_prime = 1'b0;
      6'd11: is_prime = 1'b1;
      6'd12: is_prime = 1'b0;
      6'd13: is_prime = 1'b1;
      6'd14: is_prime = 1'b0;
      6'd15: is_prime = 1'b0;
      6'd16: is_prime = 1'b0;
      6'd17: is_prime = 1'b1;
      6'd18: is_prime = 1'b0;
      6'd19: is_prime = 1'b1;
      6'd20: is_prime = 1'b0;
      6'd21: is_prime = 1'b0;
      6'd22: is_prime = 1'b0;
      6'd23: is_prime = 1'b1;
      6'd24: is_prime = 1'b0;
      6'd25: is_prime = 1'b0;
      6'd26: is_prime = 1'b0;
      6'd27: is_prime = 1'b0;
      6'd28: is_prime = 1'b0;
      6'd29: is_prime = 1'b1;
      6'd30: is_prime = 1'b0;
      6'd31: is_prime = 1'b1;
      6'd32: is_prime = 1'b0;
      6'd33: is_prime = 1'b0;
      6'd34: is_prime = 1'b0;
      6'd35: is_prime = 1'b0;
      6'd36: is_prime = 1'b0;
      6'd37: is_prime = 1'b1;
      6'd38: is_prime = 1'b0;
      6'd39: is_prime = 1'b0;
      6'd40: is_prime = 1'b0;
      6'd41: is_prime = 1'b1;
      6'd42: is_prime = 1'b0;
      6'd43: is_prime = 1'b1;
      6'd44: is_prime = 1'b0;
      6'd45: is_prime = 1'b0;
      6'd46: is_prime = 1'b0;
      6'd47: is_prime = 1'b1;
      6'd48: is_prime = 1'b0;
      6'd49: is_prime = 1'b0;
      6'd50: is_prime = 1'b0;
      6'd51: is_prime = 1'b0;
      6'd52: is_prime = 1'b0;
      6'd53: is_prime = 1'b1;
      6'd54: is_prime = 1'b0;
      6'd55: is_prime = 1'b0;
      6'd56: is_prime = 1'b0;
      6'd57: is_prime = 1'b0;
      6'd58: is_prime = 1'b0;
      6'd59: is_prime = 1'b1;
      6'd60: is_prime = 1'b0;
      6'd61: is_prime = 1'b1;
      6'd62: is_prime = 1'b0;
      6'd63: is_prime = 1'b0;
    endcase
  end

endmodule

// File: rtl/mystery_prime_detector.sv
// Registered prime detector: captures {a..f}, decodes primality, registers the flag.
module mystery_prime_detector
  import mystery_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic a,
  input  logic b,
  input  logic c,
  input  logic d,
  input  logic e,
  input  logic f,
  output logic x
);

  logic [N_W-1:0] n_q;
  logic           prime_c;

  mystery_prime_lut u_lut (
    .n        (n_q),
    .is_prime (prime_c)
  );

  // Two-stage pipeline: input capture then registered decode; reset clears both.
  always_ff @(posedge clk) begin
    if (reset) begin
      n_q <= N_W'(0);
      x   <= 1'b0;
    end else begin
      n_q <= {a, b, c, d, e, f};
      x   <= prime_c;
    end
  end

endmodule

// File: tb/tb_mystery_prime_detector.sv
// Directed self-checking bench for mystery_prime_detector.
module tb_mystery_prime_detector;

  logic clk = 1'b0;
  logic reset;
  logic a, b, c, d, e, f;
  logic x;

  int checks = 0;
  int errors = 0;
  int ones   = 0;

  mystery_prime_detector dut (
    .clk   (clk),
    .reset (reset),
    .a     (a),
    .b     (b),
    .c     (c),
    .d     (d),
    .e     (e),
    .f     (f),
    .x     (x)
  );

  always #5 clk = ~clk;

  // Independent reference: trial division.
  function automatic logic ref_prime(input int v);
    if (v < 2) return 1'b0;
    for (int i = 2; i * i <= v; i++)
      if (v % i == 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic check_eq(input string tag, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Present n with reset r for one edge, then check x one step after that edge.
  task automatic drive(input int n, input logic r, input logic exp, input string tag);
    logic [5:0] nv;
    nv = 6'(n);
    {a, b, c, d, e, f} = nv;
    reset = r;
    @(posedge clk);
    #1;
    check_eq($sformatf("%s n=%0d r=%0b", tag, n, r), int'(x), int'(exp));
  endtask

  initial begin
    reset = 1'b1;
    {a, b, c, d, e, f} = 6'd2;

    // Reset held 3 cycles with N=2, then release.
    for (int i = 0; i < 3; i++) drive(2, 1'b1, 1'b0, "reset_hold");
    drive(2, 1'b0, 1'b0, "release_edge1");
    drive(2, 1'b0, 1'b1, "release_edge2");

    // Exhaustive sweep, x at step k shows decode of N presented at step k-1.
    drive(0, 1'b1, 1'b0, "pre_sweep_rst");
    for (int k = 0; k < 64; k++) begin
      drive(k, 1'b0, (k == 0) ? 1'b0 : ref_prime(k - 1), "sweep");
      if (k > 0 && x === 1'b1) ones++;
    end
    drive(0, 1'b0, ref_prime(63), "sweep_flush");
    if (x === 1'b1) ones++;
    check_eq("sweep_ones", ones, 18);

    // Boundaries and composites, hand-computed expectations.
    drive(0,  1'b1, 1'b0, "bnd_rst");
    drive(0,  1'b0, 1'b0, "bnd_after_rst");
    drive(1,  1'b0, 1'b0, "bnd_x_of_0");
    drive(2,  1'b0, 1'b0, "bnd_x_of_1");
    drive(63, 1'b0, 1'b1, "bnd_x_of_2");
    drive(61, 1'b0, 1'b0, "bnd_x_of_63");
    drive(4,  1'b0, 1'b1, "bnd_x_of_61");
    drive(9,  1'b0, 1'b0, "comp_x_of_4");
    drive(15, 1'b0, 1'b0, "comp_x_of_9");
    drive(25, 1'b0, 1'b0, "comp_x_of_15");
    drive(49, 1'b0, 1'b0, "comp_x_of_25");
    drive(0,  1'b0, 1'b0, "comp_x_of_49");

    // Back-to-back toggling 31/32.
    drive(0,  1'b1, 1'b0, "tog_rst");
    drive(31, 1'b0, 1'b0, "tog_first");
    for (int i = 0; i < 4; i++) begin
      drive(32, 1'b0, 1'b1, "tog_x_of_31");
      drive(31, 1'b0, 1'b0, "tog_x_of_32");
    end
    drive(0,  1'b0, 1'b1, "tog_last_31");
    drive(0,  1'b0, 1'b0, "tog_flush");

    // Mid-stream reset at N=37: in-flight 31 and 37 are discarded.
    drive(0,  1'b1, 1'b0, "mid_pre_rst");
    drive(29, 1'b0, 1'b0, "mid_after_rst");
    drive(31, 1'b0, 1'b1, "mid_x_of_29");
    drive(37, 1'b1, 1'b0, "mid_rst_edge1");
    drive(41, 1'b0, 1'b0, "mid_rst_edge2");
    drive(43, 1'b0, 1'b1, "mid_x_of_41");
    drive(44, 1'b0, 1'b1, "mid_x_of_43");
    drive(0,  1'b0, 1'b0, "mid_x_of_44");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
